button_event_arbiter: RTL
=========================

# button_event_arbiter

Front-end scheduler for the processor's push-button inputs. Each raw button level is synchronized and reduced to a single rising-edge event. Events are latched as pending, then issued one at a time to the downstream processor controller over a valid/ack handshake, with round-robin fairness between buttons. A programmable lockout gap separates consecutive issued events.

## Interface
Parameters:
- N_BTN, 4: number of button inputs; legal range 2..8.
- LOCKOUT_CYCLES, 8: idle cycles enforced after each acknowledged event; legal range 0..255.

Ports:
- Clk  input  1  single system clock; all logic on posedge.
- ResetN  input  1  asynchronous, active-low reset.
- Bi  input  N_BTN  raw, asynchronous button levels; 1 = pressed.
- EvValid  output  1  an event is offered downstream.
- EvId  output  $clog2(N_BTN)  index of the offered button; valid only while EvValid=1.
- EvAck  input  1  downstream accepts the offered event.
- Pending  output  N_BTN  per-button latched, not-yet-acknowledged events.
- Busy  output  1  high in GRANT or LOCKOUT.

## Operation
- Per button there is a 3-flop chain: s1, s2, s3, where s3 is the previous value of s2. Edge[i] = s2 & ~s3.
- Pending[i] sets on Edge[i]. It clears on the ack of button i. If the set and the clear fall in the same cycle, the set wins and Pending[i] stays 1.
- An edge on a button whose Pending bit is already 1 is merged; no second event is produced.
- FSM states:
  - IDLE to GRANT when any Pending bit is 1. Select the first set bit searching upward (with wrap) from index Ptr. Register the chosen index into EvId.
  - GRANT holds EvValid=1 with EvId stable until EvAck=1 is sampled. On that edge: clear Pending[EvId], set Ptr = EvId+1 modulo N_BTN, load Cnt = LOCKOUT_CYCLES, then go to LOCKOUT, or to IDLE if LOCKOUT_CYCLES=0.
  - LOCKOUT decrements Cnt each cycle and goes to IDLE on the cycle Cnt reaches 1. Edges keep latching into Pending during LOCKOUT.
- EvAck is ignored outside GRANT.
- The round-robin pointer Ptr is $clog2(N_BTN) bits wide and wraps from N_BTN-1 to 0.

## Timing
- Reset values:
  - State=IDLE, Ptr=0, Cnt=0.
  - s1, s2 and s3 are all 0.
  - Pending=0, EvValid=0, EvId=0, Busy=0.
- Reset is asynchronous and takes effect mid-handshake: an offered event is withdrawn and all pending events are discarded.
- A button held through reset release produces exactly one event, because the sync flops reset to 0.
- Latency, counted from the first posedge that samples Bi[i]=1:
  - s1=1 after edge 1, s2=1 after edge 2.
  - Pending[i]=1 after edge 3.
  - EvValid=1 after edge 4 (when IDLE and nothing else has priority).
- The minimum pulse width on Bi for guaranteed capture is 2 clock periods.
- Handshake: EvValid falls the cycle after the EvAck edge. Back-to-back issues are separated by LOCKOUT_CYCLES+1 idle cycles, where EvValid=0.
- When EvAck is held high continuously and LOCKOUT_CYCLES=0, one event is issued every 2 cycles.

## Configuration
- BTN_EVT_DROP_CNT_EN: when defined, adds output DropCnt [7:0].
  - It increments on every merged edge, i.e. Edge[i] while Pending[i]=1 and i is not cleared that cycle.
  - It saturates at 255 and resets to 0.
  - When undefined, the port and the counter are absent and behaviour is otherwise identical.

## Test plan
- Reset, then Bi[2] high for 5 cycles -> Pending=4'b0100 after edge 3, EvValid=1 with EvId=2 after edge 4. Ack at edge 6 -> EvValid=0, Busy stays 1 for 8 cycles, exactly one event.
- Bi=4'b1111 pulsed together, EvAck tied 1 -> EvId sequence 0,1,2,3, each separated by 9 idle cycles. Ptr ends at 0.
- Bi[1] is pressed again during its own GRANT before the ack -> merged, only one event. With the macro defined, DropCnt=1.
- Press on Bi[3] coinciding with the ack of button 3 -> Pending[3] remains 1 and a second event with EvId=3 follows the lockout.
- ResetN is pulled low for 1 cycle mid-GRANT -> EvValid=0 and Pending=0 immediately. A button still held after release yields one new event 4 edges later.
- LOCKOUT_CYCLES=0, N_BTN=2, both buttons pending, EvAck=1 -> events alternate every 2 cycles, EvId sequence 0,1.

Source files
------------

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: synchronizes push buttons, latches edge events, issues them round-robin over valid/ack with a lockout gap.
// Optional merged-edge counter output DropCnt enabled by defining BTN_EVT_DROP_CNT_EN.
module button_event_arbiter #(
    parameter int N_BTN          = 4,
    parameter int LOCKOUT_CYCLES = 8
) (
    input  logic                     Clk,
    input  logic                     ResetN,
    input  logic [N_BTN-1:0]         Bi,
    output logic                     EvValid,
    output logic [$clog2(N_BTN)-1:0] EvId,
    input  logic                     EvAck,
    output logic [N_BTN-1:0]         Pending,
    output logic                     Busy
`ifdef BTN_EVT_DROP_CNT_EN
    ,output logic [7:0]              DropCnt
`endif
);
    localparam int W = $clog2(N_BTN);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_LOCK  = 2'd2;
    localparam logic [7:0] LOCK_CNT = LOCKOUT_CYCLES[7:0];
    localparam logic [W-1:0] LAST_ID = W'(N_BTN - 1);
    localparam logic [W:0] N_WIDE = (W+1)'(N_BTN);

    logic [N_BTN-1:0] s1_q, s2_q, s3_q;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [1:0]       state_q, state_d;
    logic [W-1:0]     ptr_q, ptr_d;
    logic [W-1:0]     id_q, id_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [N_BTN-1:0] btn_edge, clr, rot;
    logic             ack_w;
    logic [W-1:0]     off, sel;
    logic [W:0]       sum;

    assign btn_edge = s2_q & ~s3_q;
    assign ack_w    = (state_q == S_GRANT) && EvAck;
    assign clr      = {{(N_BTN-1){1'b0}}, ack_w} << id_q;
    // Set beats clear so an edge coinciding with its own ack is kept.
    assign pend_d   = (pend_q & ~clr) | btn_edge;
    assign rot      = N_BTN'({pend_q, pend_q} >> ptr_q);

    always_comb begin
        off = '0;
        for (int k = N_BTN - 1; k >= 0; k--)
            if (rot[k]) off = W'(k);
    end

    assign sum = {1'b0, ptr_q} + {1'b0, off};
    assign sel = (sum >= N_WIDE) ? W'(sum - N_WIDE) : sum[W-1:0];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            if (|pend_q) begin
                state_d = S_GRANT;
                id_d    = sel;
            end
        end else if (state_q == S_GRANT) begin
            if (EvAck) begin
                ptr_d   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
                cnt_d   = LOCK_CNT;
                state_d = (LOCK_CNT == 8'd0) ? S_IDLE : S_LOCK;
            end
        end else begin
            cnt_d   = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
            state_d = (cnt_q <= 8'd1) ? S_IDLE : state_q;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= Bi;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign EvValid = (state_q == S_GRANT);
    assign EvId    = id_q;
    assign Pending = pend_q;
    assign Busy    = (state_q != S_IDLE);

`ifdef BTN_EVT_DROP_CNT_EN
    logic [N_BTN-1:0] merged;
    logic [3:0]       n_merged;
    logic [8:0]       drop_sum;
    logic [7:0]       drop_q, drop_d;

    assign merged = btn_edge & pend_q & ~clr;

    always_comb begin
        n_merged = '0;
        for (int k = 0; k < N_BTN; k++)
            n_merged = n_merged + 4'(merged[k]);
    end

    assign drop_sum = {1'b0, drop_q} + 9'(n_merged);
    assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) drop_q <= '0;
        else         drop_q <= drop_d;
    end

    assign DropCnt = drop_q;
`endif
endmodule
